// File: rtl/cordic_pkg.sv
// Shared constants and types for the vectoring CORDIC: turn-scaled atan
// table, 1/K gain constant, FSM state encoding and counter width helper.
package cordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_GAIN,
        ST_DONE
    } cordic_state_e;

    // round(atan(2^-i) * 2^32 / (2*pi))
    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // 1/K = 0.6072529350 as Q0.32
    localparam logic [31:0] INV_K_Q32 = 32'h9B74EDA8;

    function automatic int iter_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives y toward zero and
// accumulates the applied rotation angle in z.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SW    = 5
) (
    input  logic signed [WIDTH+1:0] x_i,
    input  logic signed [WIDTH+1:0] y_i,
    input  logic        [WIDTH-1:0] z_i,
    input  logic        [SW-1:0]    shift_i,
    input  logic        [WIDTH-1:0] atan_i,
    output logic signed [WIDTH+1:0] x_o,
    output logic signed [WIDTH+1:0] y_o,
    output logic        [WIDTH-1:0] z_o
);

    logic signed [WIDTH+1:0] xs;
    logic signed [WIDTH+1:0] ys;

    always_comb begin
        xs = x_i >>> shift_i;
        ys = y_i >>> shift_i;
        if (!y_i[WIDTH+1]) begin
            x_o = x_i + ys;
            y_o = y_i - xs;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - ys;
            y_o = y_i + xs;
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> binary-angle phase and magnitude.
// Define CORDIC_VEC_GAIN_COMP_EN to add a GAIN cycle that removes the K gain.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int ITERATIONS = 22
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic        [WIDTH-1:0] angle_o,
    output logic        [WIDTH:0]   magnitude_o,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int DW = WIDTH + 2;
    localparam int CW = iter_w(ITERATIONS);
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    cordic_state_e state_q, state_d;
    logic signed [DW-1:0] x_q, x_d, x_n;
    logic signed [DW-1:0] y_q, y_d, y_n;
    logic [WIDTH-1:0] z_q, z_d, z_n;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] angle_q, angle_d;
    logic [WIDTH:0]   mag_q, mag_d;
    logic [WIDTH-1:0] atan_i;

    assign atan_i = WIDTH'(ATAN_TABLE[5'(cnt_q)] >> (32 - WIDTH));

    cordic_vec_stage #(
        .WIDTH(WIDTH),
        .SW   (CW)
    ) u_stage (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .shift_i(cnt_q),
        .atan_i (atan_i),
        .x_o    (x_n),
        .y_o    (y_n),
        .z_o    (z_n)
    );

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int PW = 2 * WIDTH + 2;
    localparam logic [63:0] INV_K_R =
        (((64'(INV_K_Q32) << 1) >> (32 - WIDTH)) + 64'd1) >> 1;
    localparam logic [WIDTH:0] INV_K = (WIDTH+1)'(INV_K_R);

    logic [PW-1:0] prod;
    logic [WIDTH:0] mag_gain;

    // x is non-negative after the fold, so an unsigned product is exact
    always_comb begin
        prod     = PW'(x_q[WIDTH:0]) * PW'(INV_K);
        mag_gain = (WIDTH+1)'((prod + (PW'(1) << (WIDTH - 1))) >> WIDTH);
    end
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        angle_d     = angle_q;
        mag_d       = mag_q;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    x_d        = DW'(x_i);
                    y_d        = DW'(y_i);
                    zero_d     = (x_i == '0) && (y_i == '0);
                    in_ready_d = 1'b0;
                    state_d    = ST_PRE;
                end
            end
            ST_PRE: begin
                // Fold left half-plane into the right; add 180 degrees
                if (x_q[DW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = {1'b1, {(WIDTH-1){1'b0}}};
                end else begin
                    z_d = '0;
                end
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                x_d   = x_n;
                y_d   = y_n;
                z_d   = z_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    state_d     = ST_GAIN;
`else
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    angle_d     = zero_q ? '0 : z_n;
                    mag_d       = (WIDTH+1)'(x_n);
`endif
                end
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            ST_GAIN: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                angle_d     = zero_q ? '0 : z_q;
                mag_d       = mag_gain;
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            angle_q     <= angle_d;
            mag_q       <= mag_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign angle_o     = angle_q;
    assign magnitude_o = mag_q;

endmodule
